// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with one-pixel registered colour and sync stage.
// Define VGA_TESTPAT_EN to add a Testpat input that replaces colour with 8 bars.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
`ifdef VGA_TESTPAT_EN
  input  logic       Testpat,
`endif
  output logic       Pix_en,
  output logic [9:0] Hcount,
  output logic [8:0] Vcount,
  output logic       Visible,
  output logic       Frame_start,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [7:0] Vga_r,
  output logic [7:0] Vga_g,
  output logic [7:0] Vga_b,
  output logic       Hsync,
  output logic       Vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          h_last, v_last;

  // Gated so Pix_en stays low in reset even when CLK_DIV=1.
  assign Pix_en      = (div_q == DIV_LAST) & ~Reset;
  assign h_last      = (h_q == H_LAST);
  assign v_last      = (v_q == V_LAST);
  assign Frame_start = Pix_en & h_last & v_last;

  assign Hcount  = h_q;
  assign Vcount  = (v_q < V_VIS) ? v_q[8:0] : 9'd0;
  assign Visible = (h_q < H_VIS) && (v_q < V_VIS);

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (Pix_en) begin
      h_d = h_last ? 10'd0 : h_q + 10'd1;
      if (h_last)
        v_d = v_last ? 10'd0 : v_q + 10'd1;
    end
  end

`ifdef VGA_TESTPAT_EN
  logic [2:0] bar;
  assign bar = 3'(h_q / 10'(H_ACTIVE / 8));
`endif

  always_comb begin
    hs_d  = (h_q >= HS_BEG && h_q <= HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_d  = (v_q >= VS_BEG && v_q <= VS_END) ? SYNC_POL : ~SYNC_POL;
    rgb_d = {Red_in, Green_in, Blue_in};
`ifdef VGA_TESTPAT_EN
    if (Testpat) begin
      unique case (bar)
        3'd0: rgb_d = 24'hFFFFFF;
        3'd1: rgb_d = 24'hFFFF00;
        3'd2: rgb_d = 24'h00FFFF;
        3'd3: rgb_d = 24'h00FF00;
        3'd4: rgb_d = 24'hFF00FF;
        3'd5: rgb_d = 24'hFF0000;
        3'd6: rgb_d = 24'h0000FF;
        3'd7: rgb_d = 24'h000000;
      endcase
    end
`endif
    if (!Visible)
      rgb_d = '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      rgb_q <= '0;
    end else if (Pix_en) begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign Hsync = hs_q;
  assign Vsync = vs_q;
  assign Vga_r = rgb_q[23:16];
  assign Vga_g = rgb_q[15:8];
  assign Vga_b = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster; closed-form raster model
// plus a scoreboard for the one-pixel-delayed colour/sync stage.
module tb_vga_timing_gen;

  localparam int D   = 4;
  localparam int HA  = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA  = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;

  typedef struct {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       tp;
  logic [7:0] blue;
  logic       Pix_en, Visible, Frame_start, Hsync, Vsync;
  logic [9:0] Hcount;
  logic [8:0] Vcount;
  logic [7:0] Red_in, Green_in, Blue_in, Vga_r, Vga_g, Vga_b;

  int   n_chk = 0, n_pass = 0;
  int   n = 0;
  bit   pend = 0;
  bit   fs_seen = 0;
  int   pe_cnt = 0;
  exp_t sb[$];

  always #5 Clk = ~Clk;

  assign Red_in   = Hcount[7:0];
  assign Green_in = Vcount[7:0];
  assign Blue_in  = blue;

  vga_timing_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
`ifdef VGA_TESTPAT_EN
    .Testpat(tp),
`endif
    .Pix_en(Pix_en),
    .Hcount(Hcount),
    .Vcount(Vcount),
    .Visible(Visible),
    .Frame_start(Frame_start),
    .Red_in(Red_in),
    .Green_in(Green_in),
    .Blue_in(Blue_in),
    .Vga_r(Vga_r),
    .Vga_g(Vga_g),
    .Vga_b(Vga_b),
    .Hsync(Hsync),
    .Vsync(Vsync)
  );

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h n=%0d", tag, got, exp, n);
  endtask

  function automatic logic [23:0] exp_rgb(int h, int v, logic [7:0] b,
                                          logic t);
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    if (h >= HA || v >= VA) return 24'h0;
    if (t) return bars[h / (HA / 8)];
    return {8'(h), 8'(v), b};
  endfunction

  task automatic chk_reset();
    chk("rst_pix_en", Pix_en, 0);
    chk("rst_hcount", Hcount, 0);
    chk("rst_vcount", Vcount, 0);
    chk("rst_visible", Visible, 1);
    chk("rst_frame_start", Frame_start, 0);
    chk("rst_rgb", {Vga_r, Vga_g, Vga_b}, 0);
    chk("rst_hsync", Hsync, 1);
    chk("rst_vsync", Vsync, 1);
  endtask

  task automatic sample();
    int   pix, h, v;
    bit   pe, t;
    exp_t e;
    pix = n / D;
    h   = pix % HT;
    v   = (pix / HT) % VT;
    pe  = (n % D) == D - 1;
    if (pend) begin
      e = sb.pop_front();
      chk("vga_rgb", {Vga_r, Vga_g, Vga_b}, e.rgb);
      chk("hsync", Hsync, e.hs);
      chk("vsync", Vsync, e.vs);
      pend = 0;
    end
    chk("pix_en", Pix_en, pe);
    chk("hcount", Hcount, h);
    chk("vcount", Vcount, (v < VA) ? v : 0);
    chk("visible", Visible, (h < HA && v < VA));
    chk("frame_start", Frame_start, (pe && h == HT-1 && v == VT-1));
    if (Pix_en) pe_cnt++;
    if (Frame_start) begin
      if (fs_seen) chk("frame_len", pe_cnt, HT * VT);
      fs_seen = 1;
      pe_cnt  = 0;
    end
    if (pe) begin
      blue = 8'($urandom);
      tp   = (v % 3) == 1;
`ifdef VGA_TESTPAT_EN
      t = tp;
`else
      t = 1'b0;
`endif
      e.rgb = exp_rgb(h, v, blue, t);
      e.hs  = !(h >= HA + HFP && h < HA + HFP + HS);
      e.vs  = !(v >= VA + VFP && v < VA + VFP + VS);
      sb.push_back(e);
      pend = 1;
    end
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      sample();
    end
  endtask

  initial begin
    Reset = 1'b1;
    tp    = 1'b0;
    blue  = 8'h00;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_reset();
    Reset = 1'b0;
    n = 0;
    run(HT * VT * D + 700);
    while (n % D != 1) run(1);
    Reset = 1'b1;
    #1;
    chk_reset();
    sb.delete();
    pend    = 0;
    fs_seen = 0;
    pe_cnt  = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_reset();
    Reset = 1'b0;
    n = 0;
    run(3 * HT * VT * D + 50);
    chk("sb_depth", sb.size(), pend ? 1 : 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
